// File: rtl/debounce_bank_pkg.sv
// Shared defaults and board channel indices for the push-button debounce bank.
package debounce_bank_pkg;

    localparam int DEF_CHANNELS      = 4;
    localparam int DEF_STABLE_CYCLES = 16;
    localparam int DEF_SYNC_STAGES   = 2;

    // Board channel assignment on the UART/VGA control board
    localparam int CH_HS      = 0;
    localparam int CH_VS      = 1;
    localparam int CH_DF_UART = 2;
    localparam int CH_DF_VGA  = 3;

    // Counter width able to hold 0 .. stable_cycles-1
    function automatic int cnt_width(input int stable_cycles);
        return (stable_cycles < 2) ? 1 : $clog2(stable_cycles);
    endfunction

endpackage

// File: rtl/debounce_bank_chan.sv
// One debounce channel: synchroniser, stability counter, debounced level,
// registered rise/fall pulses and a clearable toggle latch.
module debounce_bank_chan
    import debounce_bank_pkg::*;
#(
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter logic RST_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic sample_en,
    input  logic tgl_clr,
    output logic db_level,
    output logic db_rise,
    output logic db_fall,
    output logic db_toggle
);

    localparam int                CNT_W   = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   toggle_q, toggle_d;
    logic                   s_sync;
    logic                   accept;

    assign s_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], btn};
        cnt_d   = cnt_q;
        level_d = level_q;
        accept  = 1'b0;

        // Any sample matching the current level aborts a pending count
        if (s_sync == level_q) begin
            cnt_d = '0;
        end else if (sample_en) begin
            if (cnt_q == CNT_MAX) begin
                accept  = 1'b1;
                level_d = s_sync;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        rise_d = accept & s_sync;
        fall_d = accept & ~s_sync;

        if (tgl_clr) begin
            toggle_d = 1'b0;
        end else if (rise_d) begin
            toggle_d = ~toggle_q;
        end else begin
            toggle_d = toggle_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= {SYNC_STAGES{RST_LEVEL}};
            cnt_q    <= '0;
            level_q  <= RST_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            toggle_q <= toggle_d;
        end
    end

    assign db_level  = level_q;
    assign db_rise   = rise_q;
    assign db_fall   = fall_q;
    assign db_toggle = toggle_q;

endmodule

// File: rtl/debounce_bank.sv
// N-channel push-button conditioner; each channel is an independent debounce_bank_chan.
module debounce_bank
    import debounce_bank_pkg::*;
#(
    parameter int   CHANNELS      = DEF_CHANNELS,
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter logic RST_LEVEL     = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn,
    input  logic                sample_en,
    input  logic [CHANNELS-1:0] tgl_clr,
    output logic [CHANNELS-1:0] db_level,
    output logic [CHANNELS-1:0] db_rise,
    output logic [CHANNELS-1:0] db_fall,
    output logic [CHANNELS-1:0] db_toggle
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debounce_bank_chan #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES),
            .RST_LEVEL     (RST_LEVEL)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .btn       (btn[i]),
            .sample_en (sample_en),
            .tgl_clr   (tgl_clr[i]),
            .db_level  (db_level[i]),
            .db_rise   (db_rise[i]),
            .db_fall   (db_fall[i]),
            .db_toggle (db_toggle[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_debounce_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic       sample_en;
    logic [3:0] tgl_clr;
    logic [3:0] db_level, db_rise, db_fall, db_toggle;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] l;
        logic [3:0] r;
        logic [3:0] f;
        logic [3:0] t;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    debounce_bank #(
        .CHANNELS      (4),
        .STABLE_CYCLES (4),
        .SYNC_STAGES   (2),
        .RST_LEVEL     (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .sample_en (sample_en),
        .tgl_clr   (tgl_clr),
        .db_level  (db_level),
        .db_rise   (db_rise),
        .db_fall   (db_fall),
        .db_toggle (db_toggle)
    );

    always #2 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic exp_push(input int c, input string nm,
                            input logic [3:0] l, input logic [3:0] r,
                            input logic [3:0] f, input logic [3:0] t);
        exp_t e;
        e.cyc = c; e.name = nm; e.l = l; e.r = r; e.f = f; e.t = t;
        sb_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_reset();
        int c;
        c = cyc;
        rst = 1'b1; btn = 4'h0; tgl_clr = 4'h0; sample_en = 1'b1;
        exp_push(c + 1, "reset", 4'h0, 4'h0, 4'h0, 4'h0);
        wait_cyc(c + 1);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (mon_e.cyc != cyc) begin
                failures++;
                $display("FAIL %s: check for cycle %0d not reached in time (now %0d)",
                         mon_e.name, mon_e.cyc, cyc);
            end else if ({db_level, db_rise, db_fall, db_toggle} !==
                         {mon_e.l, mon_e.r, mon_e.f, mon_e.t}) begin
                failures++;
                $display("FAIL %s @cyc %0d: got lvl=%h rise=%h fall=%h tgl=%h, want lvl=%h rise=%h fall=%h tgl=%h",
                         mon_e.name, cyc, db_level, db_rise, db_fall, db_toggle,
                         mon_e.l, mon_e.r, mon_e.f, mon_e.t);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // Reset with all buttons held, then release: first sampling edge is 3
        rst = 1'b1; btn = 4'hF; sample_en = 1'b1; tgl_clr = 4'h0;
        exp_push(1, "t1_rst1", 4'h0, 4'h0, 4'h0, 4'h0);
        exp_push(2, "t1_rst2", 4'h0, 4'h0, 4'h0, 4'h0);
        exp_push(7, "t1_pre",  4'h0, 4'h0, 4'h0, 4'h0);
        exp_push(8, "t1_rise", 4'hF, 4'hF, 4'h0, 4'hF);
        exp_push(9, "t1_post", 4'hF, 4'h0, 4'h0, 4'hF);
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(12);
        do_reset();

        // Bounce on channel 0: 2-cycle runs never reach the 4-sample threshold
        c = cyc;
        for (int i = 0; i < 10; i++) begin
            exp_push(c + 2*i + 1, "t2_bounce", 4'h0, 4'h0, 4'h0, 4'h0);
            btn[0] = (i % 2 == 0);
            wait_cyc(c + 2*i + 2);
        end
        btn[0] = 1'b0;
        exp_push(c + 24, "t2_after", 4'h0, 4'h0, 4'h0, 4'h0);
        exp_push(c + 28, "t2_after", 4'h0, 4'h0, 4'h0, 4'h0);
        wait_cyc(c + 30);
        do_reset();

        // Clean press/release on channel 1
        c = cyc;
        exp_push(c + 5,  "t3_pre",   4'h0, 4'h0, 4'h0, 4'h0);
        exp_push(c + 6,  "t3_rise",  4'h2, 4'h2, 4'h0, 4'h2);
        exp_push(c + 7,  "t3_high",  4'h2, 4'h0, 4'h0, 4'h2);
        exp_push(c + 17, "t3_last",  4'h2, 4'h0, 4'h0, 4'h2);
        exp_push(c + 18, "t3_fall",  4'h0, 4'h0, 4'h2, 4'h2);
        exp_push(c + 19, "t3_low",   4'h0, 4'h0, 4'h0, 4'h2);
        btn[1] = 1'b1;
        wait_cyc(c + 12);
        btn[1] = 1'b0;
        wait_cyc(c + 22);
        do_reset();

        // Toggle on channel 2: two presses, third press cleared on its rise edge
        c = cyc;
        exp_push(c + 5,  "t4_pre",    4'h0, 4'h0, 4'h0, 4'h0);
        exp_push(c + 6,  "t4_rise1",  4'h4, 4'h4, 4'h0, 4'h4);
        exp_push(c + 7,  "t4_hold1",  4'h4, 4'h0, 4'h0, 4'h4);
        exp_push(c + 14, "t4_fall1",  4'h0, 4'h0, 4'h4, 4'h4);
        exp_push(c + 15, "t4_idle1",  4'h0, 4'h0, 4'h0, 4'h4);
        exp_push(c + 22, "t4_rise2",  4'h4, 4'h4, 4'h0, 4'h0);
        exp_push(c + 23, "t4_hold2",  4'h4, 4'h0, 4'h0, 4'h0);
        exp_push(c + 30, "t4_fall2",  4'h0, 4'h0, 4'h4, 4'h0);
        exp_push(c + 38, "t4_rise3c", 4'h4, 4'h4, 4'h0, 4'h0);
        exp_push(c + 39, "t4_hold3",  4'h4, 4'h0, 4'h0, 4'h0);
        btn[2] = 1'b1;
        wait_cyc(c + 8);
        btn[2] = 1'b0;
        wait_cyc(c + 16);
        btn[2] = 1'b1;
        wait_cyc(c + 24);
        btn[2] = 1'b0;
        wait_cyc(c + 32);
        btn[2] = 1'b1;
        wait_cyc(c + 37);
        tgl_clr[2] = 1'b1;
        wait_cyc(c + 38);
        tgl_clr[2] = 1'b0;
        wait_cyc(c + 40);
        btn[2] = 1'b0;
        wait_cyc(c + 48);
        do_reset();

        // sample_en every 3rd clock: acceptance on the 4th enabled sample
        c = cyc;
        exp_push(c + 11, "t5_pre",  4'h0, 4'h0, 4'h0, 4'h0);
        exp_push(c + 12, "t5_rise", 4'h8, 4'h8, 4'h0, 4'h8);
        exp_push(c + 13, "t5_high", 4'h8, 4'h0, 4'h0, 4'h8);
        btn[3] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            sample_en = (i % 3 == 2);
            wait_cyc(c + i + 1);
        end
        sample_en = 1'b1;
        wait_cyc(c + 18);
        do_reset();

        // Counter frozen while sample_en=0: 2 samples, long hold, 2 more samples
        c = cyc;
        sample_en = 1'b0;
        btn[3] = 1'b1;
        exp_push(c + 10, "t5_frozen", 4'h0, 4'h0, 4'h0, 4'h0);
        exp_push(c + 15, "t5_resume", 4'h0, 4'h0, 4'h0, 4'h0);
        exp_push(c + 16, "t5_rise2",  4'h8, 4'h8, 4'h0, 4'h8);
        wait_cyc(c + 2);
        sample_en = 1'b1;
        wait_cyc(c + 4);
        sample_en = 1'b0;
        wait_cyc(c + 14);
        sample_en = 1'b1;
        wait_cyc(c + 20);
        do_reset();

        // Reset after 2 counted samples restarts the full count
        c = cyc;
        exp_push(c + 5,  "t6_reset", 4'h0, 4'h0, 4'h0, 4'h0);
        exp_push(c + 10, "t6_pre",   4'h0, 4'h0, 4'h0, 4'h0);
        exp_push(c + 11, "t6_rise",  4'h1, 4'h1, 4'h0, 4'h1);
        btn[0] = 1'b1;
        wait_cyc(c + 4);
        rst = 1'b1;
        wait_cyc(c + 5);
        rst = 1'b0;
        wait_cyc(c + 14);

        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expectations left unchecked, want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
